// File: rtl/mlp_pkg.sv
// Shared types and constants for the MLP load sequencer.
package mlp_pkg;

  localparam int unsigned MLP_ROWS   = 16;
  localparam int unsigned MLP_BEATS  = 8;
  localparam int unsigned MLP_LAYERS = 8;

  localparam int unsigned ROW_W   = $clog2(MLP_ROWS);
  localparam int unsigned BEAT_W  = $clog2(MLP_BEATS);
  localparam int unsigned LAYER_W = $clog2(MLP_LAYERS);

  localparam logic LOAD_TYPE_INPUT  = 1'b1;
  localparam logic LOAD_TYPE_WEIGHT = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_IN,
    LOAD_W,
    DRAIN,
    DONE
  } seq_state_e;

  typedef struct packed {
    logic [LAYER_W-1:0] layer;
    logic [ROW_W-1:0]   row;
    logic [BEAT_W-1:0]  beat;
  } seq_pos_t;

endpackage

// File: rtl/mlp_load_sequencer_if.sv
// Host word stream plus accelerator load bus, grouped for the sequencer.
interface mlp_load_sequencer_if;
  import mlp_pkg::*;

  logic               s_valid_i;
  logic [31:0]        s_data_i;
  logic               s_ready_o;
  logic               load_en_o;
  logic [31:0]        load_payload_o;
  logic               load_type_o;
  logic [ROW_W-1:0]   input_load_number_o;
  logic [LAYER_W-1:0] layer_number_o;
  logic [BEAT_W-1:0]  weight_number_o;

  modport master (
    output s_valid_i, s_data_i,
    input  s_ready_o, load_en_o, load_payload_o, load_type_o,
    input  input_load_number_o, layer_number_o, weight_number_o
  );

  modport slave (
    input  s_valid_i, s_data_i,
    output s_ready_o, load_en_o, load_payload_o, load_type_o,
    output input_load_number_o, layer_number_o, weight_number_o
  );

endinterface

// File: rtl/mlp_seq_counter.sv
// Nested beat/row/layer position counter; beat wraps carry into row only when carry is set.
module mlp_seq_counter
  import mlp_pkg::*;
#(
  parameter int unsigned ROWS  = MLP_ROWS,
  parameter int unsigned BEATS = MLP_BEATS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  input  logic               carry,
  input  logic [LAYER_W-1:0] last_layer,
  output seq_pos_t           pos,
  output logic               beat_last,
  output logic               row_last,
  output logic               layer_last
);

  seq_pos_t pos_q, pos_d;

  assign pos        = pos_q;
  assign beat_last  = (pos_q.beat == BEAT_W'(BEATS - 1));
  assign row_last   = (pos_q.row == ROW_W'(ROWS - 1));
  assign layer_last = (pos_q.layer == last_layer);

  always_comb begin
    pos_d = pos_q;
    if (clr) begin
      pos_d = '0;
    end else if (inc) begin
      if (!beat_last) begin
        pos_d.beat = pos_q.beat + BEAT_W'(1);
      end else begin
        pos_d.beat = '0;
        // The input phase of layer 0 reuses the same row, so no carry there.
        if (carry) begin
          if (!row_last) begin
            pos_d.row = pos_q.row + ROW_W'(1);
          end else begin
            pos_d.row   = '0;
            pos_d.layer = pos_q.layer + LAYER_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

endmodule

// File: rtl/mlp_load_sequencer.sv
// Turns a host word stream into the ordered input/weight load beats of the MLP accelerator.
module mlp_load_sequencer
  import mlp_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned ROWS         = MLP_ROWS,
  parameter int unsigned BEATS        = MLP_BEATS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [LAYER_W-1:0]   last_layer_i,
  input  logic                 abort_i,
  mlp_load_sequencer_if.slave  bus,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int unsigned DrainW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  seq_state_e         state_q, state_d;
  logic [DrainW-1:0]  drain_q, drain_d;
  logic [LAYER_W-1:0] last_layer_q;
  logic               accept;
  logic               cnt_clr;
  logic               cnt_carry;
  seq_pos_t           pos;
  logic               beat_last, row_last, layer_last;

  logic               load_en_q;
  logic [31:0]        payload_q;
  logic               load_type_q;
  seq_pos_t           pos_out_q;
  logic               busy_q;
  logic               done_q;

  // Abort wins over a word offered in the same cycle, so drop ready with it.
  assign bus.s_ready_o = ((state_q == LOAD_IN) || (state_q == LOAD_W)) && !abort_i;
  assign accept        = bus.s_valid_i && bus.s_ready_o;
  assign cnt_carry     = (state_q == LOAD_W);

  mlp_seq_counter #(
    .ROWS  (ROWS),
    .BEATS (BEATS)
  ) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (cnt_clr),
    .inc        (accept),
    .carry      (cnt_carry),
    .last_layer (last_layer_q),
    .pos        (pos),
    .beat_last  (beat_last),
    .row_last   (row_last),
    .layer_last (layer_last)
  );

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    cnt_clr = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = LOAD_IN;
            cnt_clr = 1'b1;
          end
        end
        LOAD_IN: begin
          if (accept && beat_last) state_d = LOAD_W;
        end
        LOAD_W: begin
          if (accept && beat_last) begin
            if (!row_last) begin
              state_d = (pos.layer == '0) ? LOAD_IN : LOAD_W;
            end else if (layer_last) begin
              state_d = DRAIN;
              drain_d = '0;
            end
          end
        end
        DRAIN: begin
          // The first drain cycle is the one that shows the final beat.
          if (drain_q == DrainW'(DRAIN_CYCLES)) begin
            state_d = DONE;
          end else begin
            drain_d = drain_q + DrainW'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      drain_q      <= '0;
      last_layer_q <= '0;
      load_en_q    <= 1'b0;
      payload_q    <= '0;
      load_type_q  <= 1'b0;
      pos_out_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      busy_q    <= (state_d == LOAD_IN) || (state_d == LOAD_W) || (state_d == DRAIN);
      done_q    <= (state_d == DONE);
      load_en_q <= accept;
      if (cnt_clr) last_layer_q <= last_layer_i;
      if (accept) begin
        payload_q   <= bus.s_data_i;
        load_type_q <= (state_q == LOAD_IN) ? LOAD_TYPE_INPUT : LOAD_TYPE_WEIGHT;
        pos_out_q   <= pos;
      end
    end
  end

  assign bus.load_en_o           = load_en_q;
  assign bus.load_payload_o      = payload_q;
  assign bus.load_type_o         = load_type_q;
  assign bus.input_load_number_o = pos_out_q.row;
  assign bus.layer_number_o      = pos_out_q.layer;
  assign bus.weight_number_o     = pos_out_q.beat;
  assign busy_o                  = busy_q;
  assign done_o                  = done_q;

endmodule

// File: tb/tb_mlp_load_sequencer.sv
// Directed bench for mlp_load_sequencer: beat order, latency, drain/done timing, abort and reset.
module tb_mlp_load_sequencer;
  import mlp_pkg::*;

  localparam int unsigned DRAIN = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic       abort_i = 1'b0;
  logic [2:0] last_layer_i = '0;
  logic       busy_o;
  logic       done_o;

  int checks = 0;
  int errors = 0;

  mlp_load_sequencer_if bus ();

  mlp_load_sequencer #(
    .DRAIN_CYCLES (DRAIN),
    .ROWS         (16),
    .BEATS        (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .last_layer_i (last_layer_i),
    .abort_i      (abort_i),
    .bus          (bus),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input int k, input int seed);
    return {16'(2 * k + 1 + seed), 16'(2 * k + seed)};
  endfunction

  // {load_en, type, row, layer, weight, payload}
  function automatic logic [43:0] exp_beat(input int k, input int seed);
    int   row, w, layer, j;
    logic typ;
    if (k < 256) begin
      layer = 0;
      row   = k / 16;
      w     = k % 16;
      typ   = (w < 8);
      if (w >= 8) w = w - 8;
    end else begin
      j     = k - 256;
      layer = 1 + j / 128;
      row   = (j % 128) / 8;
      w     = j % 8;
      typ   = 1'b0;
    end
    return {1'b1, typ, 4'(row), 3'(layer), 3'(w), word(k, seed)};
  endfunction

  function automatic logic [43:0] obs_beat();
    return {bus.load_en_o, bus.load_type_o, bus.input_load_number_o, bus.layer_number_o,
            bus.weight_number_o, bus.load_payload_o};
  endfunction

  task automatic run(input int L, input bit bub, input int seed, input int start_at,
                     input int abort_at, input int reset_at);
    int         total, sent, got, en_cnt, cyc;
    bit         acc;
    logic [43:0] e, last_e;
    total  = 256 + 128 * L;
    sent   = 0;
    got    = 0;
    en_cnt = 0;
    cyc    = 0;
    last_e = '0;
    @(posedge clk); #1;
    start_i      = 1'b1;
    last_layer_i = 3'(L);
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("busy_after_start", busy_o, 1);
    while (got < total) begin
      if (cyc > 4 * total + 100) begin
        chk("stream_timeout", got, total);
        return;
      end
      if (sent == reset_at) begin
        bus.s_valid_i = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_outputs", {obs_beat(), busy_o, done_o, bus.s_ready_o}, 0);
        for (int i = 0; i < DRAIN + 3; i++) begin
          @(posedge clk); #1;
          chk("reset_no_done", {done_o, busy_o, bus.load_en_o}, 0);
        end
        return;
      end
      bus.s_valid_i = bub ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.s_data_i  = word(sent, seed);
      start_i       = (sent == start_at) && bus.s_valid_i;
      abort_i       = (sent == abort_at);
      #1;
      chk("s_ready", bus.s_ready_o, abort_i ? 1'b0 : 1'b1);
      acc = bus.s_valid_i && bus.s_ready_o;
      if (acc) sent++;
      @(posedge clk); #1;
      start_i = 1'b0;
      if (abort_i) begin
        abort_i       = 1'b0;
        bus.s_valid_i = 1'b0;
        chk("abort_idle", {bus.load_en_o, busy_o, done_o, bus.s_ready_o}, 0);
        for (int i = 0; i < DRAIN + 3; i++) begin
          @(posedge clk); #1;
          chk("abort_no_done", {done_o, busy_o}, 0);
        end
        return;
      end
      if (bus.load_en_o) en_cnt++;
      if (acc) begin
        e = exp_beat(got, seed);
        chk("beat", obs_beat(), e);
        last_e = e;
        got++;
      end else if (got > 0) begin
        e      = last_e;
        e[43]  = 1'b0;
        chk("hold", obs_beat(), e);
      end else begin
        chk("load_en_idle", bus.load_en_o, 0);
      end
      cyc++;
    end
    chk("load_en_count", en_cnt, total);
    // Host keeps offering words; none may be taken while draining.
    chk("drain_ready", bus.s_ready_o, 0);
    chk("drain_busy", busy_o, 1);
    for (int i = 1; i <= DRAIN + 1; i++) begin
      @(posedge clk); #1;
      chk("drain_load_en", bus.load_en_o, 0);
      chk("done_timing", done_o, (i == DRAIN + 1));
    end
    chk("busy_in_done", busy_o, 0);
    bus.s_valid_i = 1'b0;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("done_one_cycle", {done_o, busy_o}, 0);
    @(posedge clk); #1;
    chk("start_in_done_ignored", {busy_o, bus.s_ready_o}, 0);
  endtask

  initial begin
    bus.s_valid_i = 1'b0;
    bus.s_data_i  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {obs_beat(), busy_o, done_o, bus.s_ready_o}, 0);
    rst_n = 1'b1;
    run(0, 1'b0, 'h0100, 28, -1, -1);
    run(7, 1'b0, 'h2000, -1, -1, -1);
    run(1, 1'b1, 'h3000, -1, -1, -1);
    run(3, 1'b0, 'h4000, -1, 427, -1);
    run(0, 1'b1, 'h5000, -1, -1, -1);
    run(1, 1'b0, 'h6000, -1, -1, 300);
    run(0, 1'b0, 'h7000, -1, -1, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
